pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants for the pipeline controller
package pipe_ctrl_pkg;

    // Program counter width used by redirect paths.
    localparam int PC_W = 32;

    // Stall-vector bit positions, one per pipeline stage.
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;
    localparam int STG_N   = 5;

    // Hold patterns: every stage up to and including the requester is held.
    localparam logic [STG_N-1:0] STALL_NONE = 5'b00000;
    localparam logic [STG_N-1:0] STALL_IF   = 5'b00001;
    localparam logic [STG_N-1:0] STALL_LOAD = 5'b00011;
    localparam logic [STG_N-1:0] STALL_EX   = 5'b00111;
    localparam logic [STG_N-1:0] STALL_MEM  = 5'b01111;
    localparam logic [STG_N-1:0] STALL_ALL  = 5'b11111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FWAIT = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with stall counter
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   if_stallreq         instruction bus wait
//   ex_stallreq         multi-cycle EX operation busy
//   mem_stallreq        data bus wait
//   hazard_ex/_mem      register read conflicts with EX/MEM destination
//   ex_isload/mem_isload load in EX/MEM stage
//   exc_req, exc_target exception/eret pulse and its redirect PC
//   cnt_clr             synchronous clear of stall_cnt
//   stall[4:0]          per-stage hold (IF, ID, EX, MEM, WB)
//   flush, flush_pc     registered one-cycle kill with redirect PC
//   stall_cnt           saturating count of cycles with IF held
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_stallreq,
    input  logic              ex_stallreq,
    input  logic              mem_stallreq,
    input  logic              hazard_ex,
    input  logic              hazard_mem,
    input  logic              ex_isload,
    input  logic              mem_isload,
    input  logic              exc_req,
    input  logic [PC_W-1:0]   exc_target,
    input  logic              cnt_clr,
    output logic [STG_N-1:0]  stall,
    output logic              flush,
    output logic [PC_W-1:0]   flush_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t            state;
    state_t            state_nx;
    logic [PC_W-1:0]   tgt_q;
    logic [PC_W-1:0]   redirect_pc;
    logic [STG_N-1:0]  stall_run;
    logic              load_use;
    logic              bus_wait;
    logic              latch_tgt;

    assign load_use = (hazard_ex & ex_isload) | (hazard_mem & mem_isload);

    // A redirect may only be issued once no bus transaction is outstanding,
    // otherwise the in-flight access would complete into a killed pipeline.
    assign bus_wait = if_stallreq | mem_stallreq;

    // Priority order: the deepest requester wins because holding it
    // implicitly requires holding everything upstream of it.
    always_comb begin
        stall_run = STALL_NONE;
        if (mem_stallreq) begin
            stall_run = STALL_MEM;
        end else if (ex_stallreq) begin
            stall_run = STALL_EX;
        end else if (load_use) begin
            stall_run = STALL_LOAD;
        end else if (if_stallreq) begin
            stall_run = STALL_IF;
        end
    end

    always_comb begin
        state_nx  = state;
        stall     = stall_run;
        latch_tgt = 1'b0;
        case (state)
            ST_RUN: begin
                if (exc_req) begin
                    latch_tgt = 1'b1;
                    state_nx  = bus_wait ? ST_FWAIT : ST_FLUSH;
                end
            end
            ST_FWAIT: begin
                stall = STALL_ALL;
                if (!bus_wait) begin
                    state_nx = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                stall    = STALL_NONE;
                state_nx = ST_RUN;
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase
    end

    // Entering FLUSH straight from RUN uses the target arriving this cycle;
    // from FWAIT the earlier latched target is used.
    assign redirect_pc = (state == ST_RUN) ? exc_target : tgt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            tgt_q    <= '0;
            flush    <= 1'b0;
            flush_pc <= '0;
        end else begin
            state <= state_nx;
            if (latch_tgt) begin
                tgt_q <= exc_target;
            end
            flush <= (state_nx == ST_FLUSH);
            if (state_nx == ST_FLUSH) begin
                flush_pc <= redirect_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall[STG_IF] && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic ifs;
        logic exs;
        logic mems;
        logic hex;
        logic hmem;
        logic exl;
        logic meml;
        logic exc;
        logic clr;
        logic rst;
    } in_t;

    typedef struct packed {
        logic [4:0]    stall;
        logic          flush;
        logic [31:0]   fpc;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          if_stallreq, ex_stallreq, mem_stallreq;
    logic          hazard_ex, hazard_mem, ex_isload, mem_isload;
    logic          exc_req, cnt_clr;
    logic [31:0]   exc_target;
    logic [4:0]    stall;
    logic          flush;
    logic [31:0]   flush_pc;
    logic [CW-1:0] stall_cnt;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_stallreq  (if_stallreq),
        .ex_stallreq  (ex_stallreq),
        .mem_stallreq (mem_stallreq),
        .hazard_ex    (hazard_ex),
        .hazard_mem   (hazard_mem),
        .ex_isload    (ex_isload),
        .mem_isload   (mem_isload),
        .exc_req      (exc_req),
        .exc_target   (exc_target),
        .cnt_clr      (cnt_clr),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   drv_done = 0;

    // Reference model: an exception either waits for the buses or turns
    // into a one-cycle kill; the counter counts cycles in which IF is held.
    bit          m_pend;
    bit          m_flush;
    logic [31:0] m_tgt;
    logic [31:0] m_fpc;
    int          m_cnt;

    function automatic logic [4:0] run_stall(input in_t v);
        if (v.mems) return 5'b01111;
        if (v.exs) return 5'b00111;
        if ((v.hex && v.exl) || (v.hmem && v.meml)) return 5'b00011;
        if (v.ifs) return 5'b00001;
        return 5'b00000;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_flush = 0; m_tgt = '0; m_fpc = '0; m_cnt = 0;
    endtask

    task automatic drive(input in_t v, input logic [31:0] tgt);
        exp_t        e;
        logic [4:0]  s;
        bit          buses_free;
        if_stallreq  = v.ifs;  ex_stallreq = v.exs;  mem_stallreq = v.mems;
        hazard_ex    = v.hex;  hazard_mem  = v.hmem;
        ex_isload    = v.exl;  mem_isload  = v.meml;
        exc_req      = v.exc;  cnt_clr     = v.clr;
        exc_target   = tgt;    rst         = v.rst;
        if (v.rst) model_reset();
        if (m_flush) s = 5'b00000;
        else if (m_pend) s = 5'b11111;
        else s = run_stall(v);
        e.stall = s;
        e.flush = m_flush;
        e.fpc   = m_fpc;
        e.cnt   = CW'(m_cnt);
        exp_q.push_back(e);
        @(posedge clk);
        if (!v.rst) begin
            buses_free = !v.ifs && !v.mems;
            if (m_flush) begin
                m_flush = 0;
            end else if (m_pend) begin
                if (buses_free) begin
                    m_pend = 0; m_flush = 1; m_fpc = m_tgt;
                end
            end else if (v.exc) begin
                m_tgt = tgt;
                if (buses_free) begin
                    m_flush = 1; m_fpc = tgt;
                end else begin
                    m_pend = 1;
                end
            end
            if (v.clr) m_cnt = 0;
            else if (s[0] && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    function automatic in_t idle();
        in_t v;
        v = '0;
        return v;
    endfunction

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (stall !== e.stall) begin
                    bad++;
                    $display("FAIL stall t=%0t got=%b want=%b", $time, stall, e.stall);
                end
                total++;
                if (flush !== e.flush) begin
                    bad++;
                    $display("FAIL flush t=%0t got=%b want=%b", $time, flush, e.flush);
                end
                if (e.flush) begin
                    total++;
                    if (flush_pc !== e.fpc) begin
                        bad++;
                        $display("FAIL flush_pc t=%0t got=%h want=%h", $time, flush_pc, e.fpc);
                    end
                end
                total++;
                if (stall_cnt !== e.cnt) begin
                    bad++;
                    $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, e.cnt);
                end
            end else if (drv_done) begin
                break;
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        in_t v;
        if_stallreq = 0; ex_stallreq = 0; mem_stallreq = 0;
        hazard_ex = 0; hazard_mem = 0; ex_isload = 0; mem_isload = 0;
        exc_req = 0; cnt_clr = 0; exc_target = '0; rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        v = idle(); v.rst = 1;
        drive(v, '0);
        drive(v, '0);
        v = idle();
        drive(v, '0);
        drive(v, '0);

        // Deepest requester wins, then falls back when released.
        v = idle(); v.mems = 1; v.exs = 1;
        drive(v, '0);
        v = idle(); v.exs = 1;
        drive(v, '0);

        // Load-use only stalls when the producer is a load.
        v = idle(); v.hex = 1; v.exl = 1;
        drive(v, '0);
        v = idle(); v.hex = 1;
        drive(v, '0);
        v = idle(); v.hmem = 1; v.meml = 1;
        drive(v, '0);

        // Immediate redirect from idle.
        v = idle(); v.exc = 1;
        drive(v, 32'hBFC0_0380);
        v = idle();
        drive(v, '0);
        drive(v, '0);

        // Redirect held off by instruction bus; second request ignored.
        v = idle(); v.exc = 1; v.ifs = 1;
        drive(v, 32'h1234_5678);
        v = idle(); v.ifs = 1;
        drive(v, '0);
        v.exc = 1;
        drive(v, 32'h8000_0180);
        v.exc = 0;
        drive(v, '0);
        v = idle();
        drive(v, '0);
        drive(v, '0);
        drive(v, '0);

        // Counter saturation and clear, clear beating an increment.
        v = idle(); v.ifs = 1;
        for (int i = 0; i < 20; i++) drive(v, '0);
        v.clr = 1;
        drive(v, '0);
        v = idle();
        drive(v, '0);

        // Reset while a redirect waits on the data bus: no flush afterwards.
        v = idle(); v.exc = 1; v.mems = 1;
        drive(v, 32'hDEAD_BEE0);
        v = idle(); v.mems = 1;
        drive(v, '0);
        v.rst = 1;
        drive(v, '0);
        v = idle();
        for (int i = 0; i < 4; i++) drive(v, '0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            v = idle();
            v.ifs  = ($urandom_range(0, 3) == 0);
            v.exs  = ($urandom_range(0, 5) == 0);
            v.mems = ($urandom_range(0, 4) == 0);
            v.hex  = $urandom_range(0, 1);
            v.hmem = $urandom_range(0, 1);
            v.exl  = ($urandom_range(0, 3) == 0);
            v.meml = ($urandom_range(0, 3) == 0);
            v.exc  = ($urandom_range(0, 7) == 0);
            v.clr  = ($urandom_range(0, 15) == 0);
            v.rst  = ($urandom_range(0, 63) == 0);
            drive(v, $urandom);
        end
        drv_done = 1;
    end

endmodule
